add_accum: RTL and testbench
============================

ADD_ACCUM -- requirements
Module: add_accum

Interface
- REQ-001: Parameter BIT_NUM, default 4, operand width of the upstream adder (O width).
- REQ-002: Parameter ACC_LEN, default 4, number of adder results summed per block (>=1).
- REQ-003: Parameter ACC_BIT_NUM, default 8, accumulator and out_sum width (>= BIT_NUM+1).
- REQ-004: clk  input  1  single clock; all state changes on rising edge.
- REQ-005: reset  input  1  asynchronous, active-low reset.
- REQ-006: clear  input  1  synchronous block abort, active-high.
- REQ-007: in_valid  input  1  adder result {C_in,O_in} is valid this cycle.
- REQ-008: in_ready  output  1  block can accept a result this cycle.
- REQ-009: O_in  input  BIT_NUM  adder sum.
- REQ-010: C_in  input  1  adder carry-out.
- REQ-011: out_valid  output  1  completed block total available.
- REQ-012: out_ready  input  1  downstream accepts the total.
- REQ-013: out_sum  output  ACC_BIT_NUM  block total, modulo 2^ACC_BIT_NUM.
- REQ-014: out_ovf  output  1  block total exceeded ACC_BIT_NUM bits.
- REQ-015: blk_cnt  output  8  number of completed output handshakes, wraps 255->0.

Function
- REQ-016: Each input sample SHALL be the BIT_NUM+1-bit value {C_in,O_in}, zero-extended to ACC_BIT_NUM.
- REQ-017: A sample SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
- REQ-018: The FSM SHALL have states IDLE, ACCUM and HOLD.
- REQ-019: in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD, forced to 0 in any cycle with clear=1.
- REQ-020: IDLE, accept: acc <= sample, cnt <= 1; next state ACCUM, or HOLD if ACC_LEN=1.
- REQ-021: ACCUM, accept: acc <= acc+sample, cnt <= cnt+1; when cnt+1 = ACC_LEN next state HOLD.
- REQ-022: IDLE/ACCUM with no accept SHALL hold acc, cnt and state.
- REQ-023: Entering HOLD SHALL register out_sum = final acc and out_valid = 1 on the same edge, i.e. out_valid rises one cycle after the ACC_LEN-th accept.
- REQ-024: In HOLD, out_valid, out_sum and out_ovf SHALL remain stable until out_valid=1 and out_ready=1.
- REQ-025: On the output handshake: next state IDLE, out_valid <= 0, acc <= 0, cnt <= 0, out_ovf <= 0, blk_cnt <= blk_cnt+1.
- REQ-026: No input SHALL be accepted in the output-handshake cycle (no bypass); the next block starts no earlier than the following cycle.
- REQ-027: Any addition whose true result exceeds 2^ACC_BIT_NUM-1 SHALL wrap the accumulator modulo 2^ACC_BIT_NUM and set a sticky block-overflow flag, copied to out_ovf on entry to HOLD.
- REQ-028: clear=1 SHALL, on the next edge from any state, force IDLE, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0; blk_cnt unchanged; clear overrides a simultaneous output handshake (blk_cnt not incremented).
- REQ-029: out_ready while out_valid=0 SHALL have no effect.

Reset
- REQ-030: reset=0 SHALL immediately, without a clock edge, force IDLE, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0, blk_cnt=0.
- REQ-031: Reset asserted mid-block or in HOLD SHALL discard the partial or pending total; nothing SHALL be emitted after release.
- REQ-032: After reset release, in_ready SHALL be 1 in the first cycle.

Verification (BIT_NUM=4, ACC_LEN=4, ACC_BIT_NUM=8 unless noted)
- REQ-033: Reset pulse low -> out_valid=0, out_sum=0, out_ovf=0, blk_cnt=0 without a clock; in_ready=1 after release.
- REQ-034: Accept {C,O}=1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after 4th accept, out_sum=10, out_ovf=0; next cycle out_valid=0, blk_cnt=1.
- REQ-035: Same block, out_ready=0 for 5 cycles with in_valid=1 -> out_valid/out_sum=10 held, in_ready=0, no samples consumed; out_ready=1 completes, next block sums only later samples.
- REQ-036: ACC_BIT_NUM=6, four samples C=1,O=15 (31 each) -> out_sum=60 (124 mod 64), out_ovf=1; next block 1,1,1,1 -> out_sum=4, out_ovf=0.
- REQ-037: Accept 5,5, then clear=1 one cycle -> in_ready=0 in that cycle; following block 1,1,1,1 -> out_sum=4, blk_cnt unchanged by clear.
- REQ-038: reset=0 asynchronously while in HOLD with out_sum=10 -> out_valid drops immediately; after release no output until 4 new accepts.

Source files
------------

// File: rtl/add_accum.sv
// Block accumulator: sums ACC_LEN adder results {C_in,O_in} and presents the
// total through a valid/ready output stage with a sticky overflow flag.
module add_accum #(
    parameter int BIT_NUM     = 4,
    parameter int ACC_LEN     = 4,
    parameter int ACC_BIT_NUM = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIT_NUM-1:0]     O_in,
    input  logic                   C_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_BIT_NUM-1:0] out_sum,
    output logic                   out_ovf,
    output logic [7:0]             blk_cnt
);

    localparam int CNT_W = $clog2(ACC_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(ACC_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state_r, next_state_s;
    logic [ACC_BIT_NUM-1:0] acc_r, acc_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic                   ovf_r, ovf_nxt_s;
    logic                   out_valid_r, out_valid_nxt_s;
    logic [ACC_BIT_NUM-1:0] out_sum_r, out_sum_nxt_s;
    logic                   out_ovf_r, out_ovf_nxt_s;
    logic [7:0]             blk_cnt_r, blk_cnt_nxt_s;
    logic                   in_ready_s;
    logic [ACC_BIT_NUM-1:0] sample_s;
    logic [ACC_BIT_NUM:0]   sum_s;

    // The extra top bit of sum_s is the carry out of the accumulator.
    assign sample_s = ACC_BIT_NUM'({C_in, O_in});
    assign sum_s    = {1'b0, acc_r} + {1'b0, sample_s};

    // Next-state, datapath and in_ready decode.
    always_comb begin
        next_state_s    = state_r;
        acc_nxt_s       = acc_r;
        cnt_nxt_s       = cnt_r;
        ovf_nxt_s       = ovf_r;
        out_valid_nxt_s = out_valid_r;
        out_sum_nxt_s   = out_sum_r;
        out_ovf_nxt_s   = out_ovf_r;
        blk_cnt_nxt_s   = blk_cnt_r;
        in_ready_s      = 1'b0;
        if (clear) begin
            next_state_s    = IDLE;
            acc_nxt_s       = {ACC_BIT_NUM{1'b0}};
            cnt_nxt_s       = {CNT_W{1'b0}};
            ovf_nxt_s       = 1'b0;
            out_valid_nxt_s = 1'b0;
            out_sum_nxt_s   = {ACC_BIT_NUM{1'b0}};
            out_ovf_nxt_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    in_ready_s = 1'b1;
                    if (in_valid) begin
                        if (state_r == IDLE) begin
                            acc_nxt_s = sample_s;
                            ovf_nxt_s = 1'b0;
                            cnt_nxt_s = CNT_W'(1);
                        end else begin
                            acc_nxt_s = sum_s[ACC_BIT_NUM-1:0];
                            ovf_nxt_s = ovf_r | sum_s[ACC_BIT_NUM];
                            cnt_nxt_s = cnt_r + CNT_W'(1);
                        end
                        // Last sample of the block: publish the total on this edge.
                        if (cnt_nxt_s == LEN_C) begin
                            next_state_s    = HOLD;
                            out_valid_nxt_s = 1'b1;
                            out_sum_nxt_s   = acc_nxt_s;
                            out_ovf_nxt_s   = ovf_nxt_s;
                        end else begin
                            next_state_s = ACCUM;
                        end
                    end else begin
                        next_state_s = state_r;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        next_state_s    = IDLE;
                        out_valid_nxt_s = 1'b0;
                        acc_nxt_s       = {ACC_BIT_NUM{1'b0}};
                        cnt_nxt_s       = {CNT_W{1'b0}};
                        ovf_nxt_s       = 1'b0;
                        out_ovf_nxt_s   = 1'b0;
                        blk_cnt_nxt_s   = blk_cnt_r + 8'd1;
                    end else begin
                        next_state_s = HOLD;
                    end
                end
                default: begin
                    next_state_s    = IDLE;
                    acc_nxt_s       = {ACC_BIT_NUM{1'b0}};
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    ovf_nxt_s       = 1'b0;
                    out_valid_nxt_s = 1'b0;
                    out_sum_nxt_s   = {ACC_BIT_NUM{1'b0}};
                    out_ovf_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            acc_r       <= {ACC_BIT_NUM{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_sum_r   <= {ACC_BIT_NUM{1'b0}};
            out_ovf_r   <= 1'b0;
            blk_cnt_r   <= 8'd0;
        end else begin
            state_r     <= next_state_s;
            acc_r       <= acc_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ovf_r       <= ovf_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_sum_r   <= out_sum_nxt_s;
            out_ovf_r   <= out_ovf_nxt_s;
            blk_cnt_r   <= blk_cnt_nxt_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_ovf   = out_ovf_r;
    assign blk_cnt   = blk_cnt_r;

endmodule

// File: tb/tb_add_accum.sv
// Bench for add_accum: 8-bit and 6-bit accumulator instances share stimulus and
// are compared every cycle against an unbounded-integer block-sum model.
module tb_add_accum;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] O_in;
    logic       C_in;

    logic       ir8, ov8, of8;
    logic [7:0] os8, bc8;
    logic       ir6, ov6, of6;
    logic [5:0] os6;
    logic [7:0] bc6;

    int checks;
    int failures;
    bit chk_en;

    int m_total;
    int m_n;
    bit m_hold;
    int m_blk;

    add_accum dut8 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir8),
        .O_in(O_in), .C_in(C_in), .out_valid(ov8), .out_ready(out_ready),
        .out_sum(os8), .out_ovf(of8), .blk_cnt(bc8)
    );

    add_accum #(.ACC_BIT_NUM(6)) dut6 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(ir6),
        .O_in(O_in), .C_in(C_in), .out_valid(ov6), .out_ready(out_ready),
        .out_sum(os6), .out_ovf(of6), .blk_cnt(bc6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Block model: a running true total of four samples, then a held result.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_total <= 0;
            m_n     <= 0;
            m_hold  <= 1'b0;
            m_blk   <= 0;
        end else if (clear) begin
            m_total <= 0;
            m_n     <= 0;
            m_hold  <= 1'b0;
        end else if (m_hold) begin
            if (out_ready) begin
                m_hold  <= 1'b0;
                m_total <= 0;
                m_n     <= 0;
                m_blk   <= (m_blk + 1) % 256;
            end
        end else if (in_valid) begin
            m_total <= m_total + int'({C_in, O_in});
            m_n     <= m_n + 1;
            if (m_n + 1 == 4) m_hold <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ir8", ir8, 32'(!clear && !m_hold));
            chk("ov8", ov8, 32'(m_hold));
            chk("bc8", bc8, 32'(m_blk));
            chk("ir6", ir6, 32'(!clear && !m_hold));
            chk("ov6", ov6, 32'(m_hold));
            chk("bc6", bc6, 32'(m_blk));
            if (m_hold) begin
                chk("os8", os8, 32'(m_total % 256));
                chk("of8", of8, 32'(m_total > 255));
                chk("os6", os6, 32'(m_total % 64));
                chk("of6", of6, 32'(m_total > 63));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic c, input logic [3:0] o);
        in_valid = 1'b1;
        C_in     = c;
        O_in     = o;
        cyc();
    endtask

    task automatic put4(input logic c, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] d, input logic [3:0] e);
        put(c, a);
        put(c, b);
        put(c, d);
        put(c, e);
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; chk_en = 1'b0;
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        C_in = 1'b0; O_in = 4'd0;
        #3 reset = 1'b0;
        #1;
        chk("rst_ov", ov8, 32'd0);
        chk("rst_os", os8, 32'd0);
        chk("rst_of", of8, 32'd0);
        chk("rst_bc", bc8, 32'd0);
        chk_en = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rel_ir", ir8, 32'd1);

        // Basic block 1+2+3+4
        out_ready = 1'b1;
        put4(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        chk("b1_ov", ov8, 32'd1);
        chk("b1_sum", os8, 32'd10);
        chk("b1_ovf", of8, 32'd0);
        cyc();
        chk("b1_done", ov8, 32'd0);
        chk("b1_blk", bc8, 32'd1);

        // Back-pressure: result held, inputs refused, no bypass on handshake
        out_ready = 1'b0;
        put4(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        in_valid = 1'b1; O_in = 4'd7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ov", ov8, 32'd1);
            chk("bp_sum", os8, 32'd10);
            chk("bp_ir", ir8, 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_blk", bc8, 32'd2);
        put4(1'b0, 4'd2, 4'd2, 4'd2, 4'd2);
        chk("nb_sum", os8, 32'd8);
        cyc();
        chk("nb_blk", bc8, 32'd3);

        // Overflow on the 6-bit instance, then a clean block
        put4(1'b1, 4'd15, 4'd15, 4'd15, 4'd15);
        chk("ovf6_sum", os6, 32'd60);
        chk("ovf6_flag", of6, 32'd1);
        chk("ovf8_sum", os8, 32'd124);
        chk("ovf8_flag", of8, 32'd0);
        cyc();
        put4(1'b0, 4'd1, 4'd1, 4'd1, 4'd1);
        chk("clr6_sum", os6, 32'd4);
        chk("clr6_flag", of6, 32'd0);
        cyc();
        chk("ovf_blk", bc8, 32'd5);

        // Clear mid-block
        put(1'b0, 4'd5);
        put(1'b0, 4'd5);
        clear = 1'b1; O_in = 4'd9;
        #1 chk("clr_ir", ir8, 32'd0);
        cyc();
        clear = 1'b0;
        chk("clr_blk", bc8, 32'd5);
        put4(1'b0, 4'd1, 4'd1, 4'd1, 4'd1);
        chk("clr_ov", ov8, 32'd1);
        chk("clr_sum", os8, 32'd4);
        cyc();
        chk("clr_blk2", bc8, 32'd6);

        // Clear beats a simultaneous output handshake
        put4(1'b0, 4'd3, 4'd3, 4'd3, 4'd3);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clrhs_ov", ov8, 32'd0);
        chk("clrhs_blk", bc8, 32'd6);

        // Async reset while holding a result
        out_ready = 1'b0;
        put4(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        chk("hr_sum", os8, 32'd10);
        #1 reset = 1'b0;
        #1;
        chk("ar_ov", ov8, 32'd0);
        chk("ar_os", os8, 32'd0);
        chk("ar_bc", bc8, 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ar_quiet", ov8, 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        put4(1'b0, 4'd1, 4'd1, 4'd1, 4'd1);
        chk("ar_new_ov", ov8, 32'd1);
        chk("ar_new_sum", os8, 32'd4);
        cyc();
        chk("ar_blk", bc8, 32'd1);

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
